uart_tx_arbiter: RTL

Round-robin arbiter that shares the single `uart_top` transmitter among `NUM_REQ` byte-stream requesters. It sits between client blocks and `uart_top`'s `tx_data/tx_valid/tx_ready` port and sequences one requester's message at a time. A grant is held until the owner marks end-of-message, exhausts the burst limit, or runs dry. Receive path is untouched.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte-stream requesters using
// round-robin arbitration. The owner keeps the grant until it marks the end
// of its message, reaches MAX_BURST bytes, or has no byte available.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   req_data     requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid    requester i has a byte
//   req_last     requester i byte is the last of its message
//   req_ready    one-hot-or-zero, requester i byte consumed this cycle
//   tx_data      byte to the UART transmitter (held between pulses)
//   tx_valid     single-cycle pulse to the UART transmitter
//   tx_ready     UART transmitter idle
//   grant_valid  a requester currently owns the transmitter
//   grant_id     index of the owner
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [ID_W-1:0]       grant_id_r, grant_id_s;
  logic [ID_W-1:0]       ptr_r, ptr_s;
  logic [7:0]            burst_cnt_r, burst_cnt_s;
  logic                  last_r, last_s;
  logic [DATA_WIDTH-1:0] tx_data_r, tx_data_s;
  logic                  tx_valid_r, tx_valid_s;
  logic                  grant_valid_r, grant_valid_s;
  logic [NUM_REQ-1:0]    req_ready_s;

  // First requester with valid set, searching ptr+1, ptr+2, ... modulo
  // NUM_REQ. Iterating from the farthest offset down lets the nearest one
  // overwrite the result last.
  function automatic logic [ID_W-1:0] pick_winner(
    input logic [NUM_REQ-1:0] valid,
    input logic [ID_W-1:0]    ptr
  );
    logic [ID_W-1:0] win;
    int              idx;
    win = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) begin
        win = ID_W'(idx);
      end
    end
    return win;
  endfunction

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_s       = state_r;
    grant_id_s    = grant_id_r;
    ptr_s         = ptr_r;
    burst_cnt_s   = burst_cnt_r;
    last_s        = last_r;
    tx_data_s     = tx_data_r;
    tx_valid_s    = 1'b0;
    grant_valid_s = grant_valid_r;
    req_ready_s   = '0;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          grant_id_s    = pick_winner(req_valid, ptr_r);
          ptr_s         = grant_id_s;
          burst_cnt_s   = 8'd0;
          grant_valid_s = 1'b1;
          state_s       = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!req_valid[grant_id_r]) begin
          // Owner ran dry: give the transmitter back.
          grant_valid_s = 1'b0;
          state_s       = IDLE;
        end else if (tx_ready) begin
          req_ready_s[grant_id_r] = 1'b1;
          tx_data_s   = req_data[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
          last_s      = req_last[grant_id_r];
          burst_cnt_s = burst_cnt_r + 8'd1;
          tx_valid_s  = 1'b1;
          state_s     = SEND;
        end else begin
          state_s = GRANT;
        end
      end
      SEND: begin
        state_s = DRAIN;
      end
      DRAIN: begin
        // tx_ready low means the UART took the byte and is framing it.
        if (!tx_ready) begin
          if (last_r || (burst_cnt_r == 8'(MAX_BURST))) begin
            grant_valid_s = 1'b0;
            state_s       = IDLE;
          end else begin
            state_s = GRANT;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        grant_valid_s = 1'b0;
        state_s       = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      grant_id_r    <= '0;
      ptr_r         <= ID_W'(NUM_REQ - 1);
      burst_cnt_r   <= 8'd0;
      last_r        <= 1'b0;
      tx_data_r     <= '0;
      tx_valid_r    <= 1'b0;
      grant_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      grant_id_r    <= grant_id_s;
      ptr_r         <= ptr_s;
      burst_cnt_r   <= burst_cnt_s;
      last_r        <= last_s;
      tx_data_r     <= tx_data_s;
      tx_valid_r    <= tx_valid_s;
      grant_valid_r <= grant_valid_s;
    end
  end

  // req_ready must be combinational so the byte is consumed in the cycle it
  // is captured; it is suppressed while reset is asserted.
  assign req_ready   = req_ready_s & {NUM_REQ{~reset}};
  assign tx_data     = tx_data_r;
  assign tx_valid    = tx_valid_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

endmodule
